// File: rtl/pe_row16_feeder.sv
// Feeds one 16-pixel feature-map row and a 3-tap weight row into a 16-wide stride-2 PE row.
// It then times the PE row's 8-column partial-sum output window.
package conv16_defs_pkg;
  localparam int conv16_width = 16;
endpackage

module pe_row16_feeder
  import conv16_defs_pkg::*;
#(
  parameter int DW        = conv16_width,
  parameter int FM_AW     = 10,
  parameter int W_AW      = 8,
  parameter int EN_CYCLES = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [FM_AW-1:0] fm_base,
  input  logic [W_AW-1:0]  w_base,
  output logic             busy,
  output logic             done,
  output logic             fm_rd,
  output logic [FM_AW-1:0] fm_addr,
  input  logic [DW-1:0]    fm_rdata,
  output logic             w_rd,
  output logic [W_AW-1:0]  w_addr,
  input  logic [DW-1:0]    w_rdata,
  output logic             pe_en,
  output logic [DW-1:0]    pe_f,
  output logic [DW-1:0]    pe_r,
  input  logic             pe_end,
  output logic             psum_vld,
  output logic [2:0]       psum_idx,
  output logic             psum_err
);

  typedef enum logic [1:0] {IDLE, RD, HOLD, GAP} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic [4:0]       en_cnt;
  logic [FM_AW-1:0] fm_base_q;
  logic [W_AW-1:0]  w_base_q;
  logic             rd_d1, wrd_d1;
  logic             pe_end_q;
  logic             win_active;
  logic [2:0]       win_cnt;
  logic             seen_rise;
  logic             accept, rise, en_last;

  // A psum window still draining after done keeps the block busy, so no new job yet.
  assign accept  = (state == IDLE) && !win_active && start;
  assign rise    = pe_end && !pe_end_q;
  assign en_last = pe_en && (en_cnt == 5'(EN_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    fm_rd     = 1'b0;
    fm_addr   = '0;
    w_rd      = 1'b0;
    w_addr    = '0;
    done      = 1'b0;
    psum_err  = 1'b0;
    busy      = (state != IDLE) || win_active;
    psum_vld  = win_active || (rise && busy);
    psum_idx  = win_active ? win_cnt : 3'd0;
    case (state)
      IDLE: if (accept) state_nxt = RD;
      RD: begin
        fm_rd   = 1'b1;
        fm_addr = fm_base_q + FM_AW'(cnt);
        if (cnt < 4'd3) begin
          w_rd   = 1'b1;
          w_addr = w_base_q + W_AW'(cnt);
        end
        if (cnt == 4'd15) state_nxt = HOLD;
      end
      HOLD: if (en_last) state_nxt = GAP;
      GAP: begin
        if (cnt == 4'd3) begin
          done      = 1'b1;
          psum_err  = !(seen_rise || rise);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      en_cnt    <= '0;
      fm_base_q <= '0;
      w_base_q  <= '0;
      rd_d1     <= 1'b0;
      wrd_d1    <= 1'b0;
      pe_en     <= 1'b0;
      pe_r      <= '0;
      pe_f      <= '0;
      pe_end_q  <= 1'b0;
      win_active <= 1'b0;
      win_cnt   <= '0;
      seen_rise <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state != state_nxt) cnt <= '0;
      else if (state == RD || state == GAP) cnt <= cnt + 4'd1;

      if (accept) begin
        fm_base_q <= fm_base;
        w_base_q  <= w_base;
        en_cnt    <= '0;
        seen_rise <= 1'b0;
      end else begin
        if (pe_en) en_cnt <= en_cnt + 5'd1;
        if (rise && state != IDLE) seen_rise <= 1'b1;
      end

      // Memory returns data one cycle after the strobe; register it once more for the PE row.
      rd_d1  <= fm_rd;
      wrd_d1 <= w_rd;
      pe_r   <= rd_d1 ? fm_rdata : '0;
      pe_f   <= wrd_d1 ? w_rdata : '0;

      if (state == RD && cnt == 4'd1) pe_en <= 1'b1;
      else if (en_last) pe_en <= 1'b0;

      pe_end_q <= pe_end;
      if (win_active) begin
        win_cnt <= win_cnt + 3'd1;
        if (win_cnt == 3'd7) win_active <= 1'b0;
      end else if (rise && busy) begin
        win_active <= 1'b1;
        win_cnt    <= 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_pe_row16_feeder.sv
// Directed bench for pe_row16_feeder: per-cycle input schedules, outputs recorded mid-cycle.
module tb_pe_row16_feeder;

  localparam int N = 80;

  logic        clk = 1'b0;
  logic        rstn, start, pe_end;
  logic [9:0]  fm_base, fm_addr;
  logic [7:0]  w_base, w_addr;
  logic        busy, done, fm_rd, w_rd, pe_en, psum_vld, psum_err;
  logic [15:0] fm_rdata, w_rdata, pe_f, pe_r;
  logic [2:0]  psum_idx;

  logic [15:0] fm_mem [1024];
  logic [15:0] w_mem  [256];

  logic        st_s [N], pe_s [N], rs_s [N];
  logic [9:0]  fb_s [N];
  logic [7:0]  wb_s [N];

  logic        r_fm_rd [N], r_w_rd [N], r_pe_en [N], r_busy [N], r_done [N], r_vld [N], r_err [N];
  logic [9:0]  r_fm_addr [N];
  logic [7:0]  r_w_addr [N];
  logic [15:0] r_pe_f [N], r_pe_r [N];
  logic [2:0]  r_idx [N];

  int n_chk = 0;
  int n_fail = 0;

  pe_row16_feeder dut (
    .clk(clk), .rstn(rstn), .start(start), .fm_base(fm_base), .w_base(w_base),
    .busy(busy), .done(done), .fm_rd(fm_rd), .fm_addr(fm_addr), .fm_rdata(fm_rdata),
    .w_rd(w_rd), .w_addr(w_addr), .w_rdata(w_rdata), .pe_en(pe_en), .pe_f(pe_f),
    .pe_r(pe_r), .pe_end(pe_end), .psum_vld(psum_vld), .psum_idx(psum_idx),
    .psum_err(psum_err)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories; junk on idle cycles so ungated data would show up.
  always @(posedge clk) begin
    fm_rdata <= fm_rd ? fm_mem[fm_addr] : 16'hDEAD;
    w_rdata  <= w_rd ? w_mem[w_addr] : 16'hBEEF;
  end

  task automatic clear_sched(input logic [9:0] fb, input logic [7:0] wb);
    for (int c = 0; c < N; c++) begin
      st_s[c] = 1'b0; pe_s[c] = 1'b0; rs_s[c] = 1'b1; fb_s[c] = fb; wb_s[c] = wb;
    end
  endtask

  // Cycle c is the clock period that ends with posedge c; inputs change just after the prior negedge.
  task automatic sim(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      start = st_s[c]; pe_end = pe_s[c]; rstn = rs_s[c]; fm_base = fb_s[c]; w_base = wb_s[c];
      #1;
      r_fm_rd[c] = fm_rd; r_fm_addr[c] = fm_addr; r_w_rd[c] = w_rd; r_w_addr[c] = w_addr;
      r_pe_en[c] = pe_en; r_pe_f[c] = pe_f; r_pe_r[c] = pe_r; r_busy[c] = busy;
      r_done[c] = done; r_vld[c] = psum_vld; r_idx[c] = psum_idx; r_err[c] = psum_err;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; pe_end = 1'b0; fm_base = '0; w_base = '0;
    #1;
    n_chk++;
    if ({busy, done, fm_rd, w_rd, pe_en, psum_vld, psum_err} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b exp 0000000", {busy, done, fm_rd, w_rd, pe_en, psum_vld, psum_err});
    end
    n_chk++;
    if ({pe_r, pe_f, fm_addr, w_addr, psum_idx} !== '0) begin
      n_fail++; $display("FAIL reset_data: pe_r=%h pe_f=%h fm_addr=%h w_addr=%h idx=%0d exp 0",
                         pe_r, pe_f, fm_addr, w_addr, psum_idx);
    end
    clear_sched(10'h010, 8'h04);
    sim(3);
  endtask

  task automatic test_single_job;
    logic e_rd, e_wrd, e_en, e_busy, e_done, e_vld;
    logic [15:0] e_r, e_f;
    clear_sched(10'h010, 8'h04);
    st_s[0] = 1'b1;
    for (int c = 15; c < 36; c++) pe_s[c] = 1'b1;
    sim(36);
    for (int c = 0; c < 36; c++) begin
      e_rd = (c >= 1 && c <= 16); e_wrd = (c >= 1 && c <= 3); e_en = (c >= 3 && c <= 26);
      e_busy = (c >= 1 && c <= 30); e_done = (c == 30); e_vld = (c >= 15 && c <= 22);
      e_r = (c >= 3 && c <= 18) ? 16'(c - 2) : 16'd0;
      e_f = (c == 3) ? 16'd2 : (c == 4) ? 16'd3 : (c == 5) ? 16'd5 : 16'd0;
      n_chk++;
      if (r_fm_rd[c] !== e_rd || (e_rd && r_fm_addr[c] !== 10'(16 + c - 1))) begin
        n_fail++; $display("FAIL job_fm c%0d: rd=%b addr=%h exp rd=%b addr=%h", c, r_fm_rd[c], r_fm_addr[c], e_rd, 10'(16 + c - 1));
      end
      n_chk++;
      if (r_w_rd[c] !== e_wrd || (e_wrd && r_w_addr[c] !== 8'(4 + c - 1))) begin
        n_fail++; $display("FAIL job_w c%0d: rd=%b addr=%h exp rd=%b addr=%h", c, r_w_rd[c], r_w_addr[c], e_wrd, 8'(4 + c - 1));
      end
      n_chk++;
      if (r_pe_en[c] !== e_en || r_pe_r[c] !== e_r || r_pe_f[c] !== e_f) begin
        n_fail++; $display("FAIL job_pe c%0d: en=%b r=%h f=%h exp en=%b r=%h f=%h", c, r_pe_en[c], r_pe_r[c], r_pe_f[c], e_en, e_r, e_f);
      end
      n_chk++;
      if (r_busy[c] !== e_busy || r_done[c] !== e_done || r_err[c] !== 1'b0) begin
        n_fail++; $display("FAIL job_ctrl c%0d: busy=%b done=%b err=%b exp busy=%b done=%b err=0", c, r_busy[c], r_done[c], r_err[c], e_busy, e_done);
      end
      n_chk++;
      if (r_vld[c] !== e_vld || (e_vld && r_idx[c] !== 3'(c - 15))) begin
        n_fail++; $display("FAIL job_psum c%0d: vld=%b idx=%0d exp vld=%b idx=%0d", c, r_vld[c], r_idx[c], e_vld, c - 15);
      end
    end
  endtask

  task automatic test_no_end;
    clear_sched(10'h010, 8'h04);
    st_s[0] = 1'b1;
    sim(34);
    for (int c = 0; c < 34; c++) begin
      n_chk++;
      if (r_vld[c] !== 1'b0 || r_err[c] !== (c == 30) || r_done[c] !== (c == 30)) begin
        n_fail++; $display("FAIL no_end c%0d: vld=%b err=%b done=%b exp vld=0 err=%b done=%b", c, r_vld[c], r_err[c], r_done[c], c == 30, c == 30);
      end
    end
  endtask

  task automatic test_start_ignored;
    logic e_rd, e_busy;
    logic [9:0] e_a;
    clear_sched(10'h100, 8'h04);
    for (int c = 0; c < 3; c++) fb_s[c] = 10'h010;
    st_s[0] = 1'b1; st_s[5] = 1'b1; st_s[20] = 1'b1; st_s[31] = 1'b1;
    sim(66);
    for (int c = 0; c < 66; c++) begin
      e_rd = (c >= 1 && c <= 16) || (c >= 32 && c <= 47);
      e_a = (c <= 16) ? 10'(16 + c - 1) : 10'(256 + c - 32);
      e_busy = (c >= 1 && c <= 30) || (c >= 32 && c <= 61);
      n_chk++;
      if (r_fm_rd[c] !== e_rd || (e_rd && r_fm_addr[c] !== e_a)) begin
        n_fail++; $display("FAIL restart_fm c%0d: rd=%b addr=%h exp rd=%b addr=%h", c, r_fm_rd[c], r_fm_addr[c], e_rd, e_a);
      end
      n_chk++;
      if (r_busy[c] !== e_busy || r_done[c] !== (c == 30 || c == 61)) begin
        n_fail++; $display("FAIL restart_ctrl c%0d: busy=%b done=%b exp busy=%b done=%b", c, r_busy[c], r_done[c], e_busy, c == 30 || c == 61);
      end
    end
  endtask

  task automatic test_addr_wrap;
    logic [9:0] e_a;
    logic [7:0] e_w;
    clear_sched(10'h3FE, 8'hFF);
    st_s[0] = 1'b1;
    sim(32);
    for (int c = 1; c <= 16; c++) begin
      e_a = 10'h3FE + 10'(c - 1);
      n_chk++;
      if (r_fm_addr[c] !== e_a) begin
        n_fail++; $display("FAIL wrap_fm c%0d: addr=%h exp %h", c, r_fm_addr[c], e_a);
      end
    end
    for (int c = 1; c <= 3; c++) begin
      e_w = 8'hFF + 8'(c - 1);
      n_chk++;
      if (r_w_addr[c] !== e_w) begin
        n_fail++; $display("FAIL wrap_w c%0d: addr=%h exp %h", c, r_w_addr[c], e_w);
      end
    end
  endtask

  task automatic test_reset_mid_job;
    clear_sched(10'h010, 8'h04);
    st_s[0] = 1'b1; rs_s[10] = 1'b0; rs_s[11] = 1'b0;
    for (int c = 20; c < 26; c++) pe_s[c] = 1'b1;
    sim(40);
    n_chk++;
    if ({r_busy[10], r_fm_rd[10], r_w_rd[10], r_pe_en[10], r_done[10], r_vld[10], r_err[10]} !== 7'b0
        || r_pe_r[10] !== 16'd0 || r_fm_addr[10] !== 10'd0) begin
      n_fail++; $display("FAIL mid_reset c10: busy=%b fm_rd=%b pe_en=%b pe_r=%h fm_addr=%h exp all 0",
                         r_busy[10], r_fm_rd[10], r_pe_en[10], r_pe_r[10], r_fm_addr[10]);
    end
    for (int c = 10; c < 40; c++) begin
      n_chk++;
      if (r_busy[c] !== 1'b0 || r_done[c] !== 1'b0 || r_err[c] !== 1'b0 || r_vld[c] !== 1'b0) begin
        n_fail++; $display("FAIL post_reset c%0d: busy=%b done=%b err=%b vld=%b exp 0", c, r_busy[c], r_done[c], r_err[c], r_vld[c]);
      end
    end
    clear_sched(10'h010, 8'h04);
    st_s[0] = 1'b1;
    sim(33);
    n_chk++;
    if (r_fm_addr[1] !== 10'h010 || r_fm_addr[16] !== 10'h01F || r_fm_rd[17] !== 1'b0) begin
      n_fail++; $display("FAIL fresh_fm: c1=%h c16=%h rd17=%b exp 010 01F 0", r_fm_addr[1], r_fm_addr[16], r_fm_rd[17]);
    end
    n_chk++;
    if (r_pe_r[3] !== 16'd1 || r_pe_r[18] !== 16'd16 || r_pe_f[3] !== 16'd2 || r_pe_f[5] !== 16'd5) begin
      n_fail++; $display("FAIL fresh_pe: r3=%h r18=%h f3=%h f5=%h exp 1 10 2 5", r_pe_r[3], r_pe_r[18], r_pe_f[3], r_pe_f[5]);
    end
    n_chk++;
    if ({r_pe_en[2], r_pe_en[3], r_pe_en[26], r_pe_en[27], r_done[29], r_done[30], r_busy[31]} !== 7'b0110010) begin
      n_fail++; $display("FAIL fresh_timing: got %b exp 0110010",
                         {r_pe_en[2], r_pe_en[3], r_pe_en[26], r_pe_en[27], r_done[29], r_done[30], r_busy[31]});
    end
  endtask

  task automatic test_window_past_done;
    logic e_vld;
    clear_sched(10'h010, 8'h04);
    st_s[0] = 1'b1; st_s[33] = 1'b1;
    pe_s[28] = 1'b1; pe_s[29] = 1'b1;
    for (int c = 31; c < 35; c++) pe_s[c] = 1'b1;
    sim(40);
    for (int c = 24; c < 40; c++) begin
      e_vld = (c >= 28 && c <= 35);
      n_chk++;
      if (r_vld[c] !== e_vld || (e_vld && r_idx[c] !== 3'(c - 28))) begin
        n_fail++; $display("FAIL late_psum c%0d: vld=%b idx=%0d exp vld=%b idx=%0d", c, r_vld[c], r_idx[c], e_vld, c - 28);
      end
      n_chk++;
      if (r_busy[c] !== (c <= 35) || r_done[c] !== (c == 30) || r_err[c] !== 1'b0 || (c > 30 && r_fm_rd[c] !== 1'b0)) begin
        n_fail++; $display("FAIL late_ctrl c%0d: busy=%b done=%b err=%b fm_rd=%b exp busy=%b done=%b err=0 fm_rd=0",
                           c, r_busy[c], r_done[c], r_err[c], r_fm_rd[c], c <= 35, c == 30);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) fm_mem[i] = 16'h7000 + 16'(i);
    for (int i = 0; i < 256; i++) w_mem[i] = 16'h0900 + 16'(i);
    for (int k = 0; k < 16; k++) fm_mem[16 + k] = 16'(k + 1);
    w_mem[4] = 16'd2; w_mem[5] = 16'd3; w_mem[6] = 16'd5;

    test_reset;
    test_single_job;
    test_no_end;
    test_start_ignored;
    test_addr_wrap;
    test_reset_mid_job;
    test_window_past_done;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
